// File: rtl/neuron_out_argmax.sv
// Argmax decision stage after the output layer: captures nine signed activations,
// scans them one per cycle and reports winning class, winning value and top-two margin.
module neuron_out_argmax #(
    parameter int                DATA_W     = 20,
    parameter logic [DATA_W-1:0] MIN_MARGIN = 20'd1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a3_1,
    input  logic signed [DATA_W-1:0] a3_2,
    input  logic signed [DATA_W-1:0] a3_3,
    input  logic signed [DATA_W-1:0] a3_4,
    input  logic signed [DATA_W-1:0] a3_5,
    input  logic signed [DATA_W-1:0] a3_6,
    input  logic signed [DATA_W-1:0] a3_7,
    input  logic signed [DATA_W-1:0] a3_8,
    input  logic signed [DATA_W-1:0] a3_9,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               class_idx,
    output logic signed [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0]        margin,
    output logic                     low_conf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_r;
    logic signed [DATA_W-1:0] buf_r [0:8];
    logic [3:0]               cnt_r;
    logic signed [DATA_W-1:0] best_r;
    logic signed [DATA_W-1:0] second_r;
    logic [3:0]               idx_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [3:0]               class_idx_r;
    logic signed [DATA_W-1:0] max_val_r;
    logic [DATA_W-1:0]        margin_r;
    logic                     low_conf_r;

    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] best_n_s;
    logic signed [DATA_W-1:0] second_n_s;
    logic [3:0]               idx_n_s;
    logic [DATA_W-1:0]        margin_s;
    logic                     low_conf_s;

    // Select the buffer element addressed by the scan counter (class cnt lives at cnt-1).
    always_comb begin
        x_s = buf_r[0];
        case (cnt_r)
            4'd2:    x_s = buf_r[1];
            4'd3:    x_s = buf_r[2];
            4'd4:    x_s = buf_r[3];
            4'd5:    x_s = buf_r[4];
            4'd6:    x_s = buf_r[5];
            4'd7:    x_s = buf_r[6];
            4'd8:    x_s = buf_r[7];
            4'd9:    x_s = buf_r[8];
            default: x_s = buf_r[0];
        endcase
    end

    // Running top-two update; strict compares keep the lower index on ties.
    always_comb begin
        best_n_s   = best_r;
        second_n_s = second_r;
        idx_n_s    = idx_r;
        if (x_s > best_r) begin
            second_n_s = best_r;
            best_n_s   = x_s;
            idx_n_s    = cnt_r;
        end else if (x_s > second_r) begin
            second_n_s = x_s;
        end else begin
            second_n_s = second_r;
        end
        // best >= second always holds, so the true difference is non-negative and
        // below 2^DATA_W; modular DATA_W-bit subtraction yields it exactly.
        margin_s   = best_n_s - second_n_s;
        low_conf_s = (margin_s < MIN_MARGIN);
    end

    // Control FSM, capture buffer, scan state and registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            class_idx_r <= 4'd0;
            max_val_r   <= '0;
            margin_r    <= '0;
            low_conf_r  <= 1'b0;
            cnt_r       <= 4'd0;
            best_r      <= '0;
            second_r    <= '0;
            idx_r       <= 4'd0;
            for (int i = 0; i < 9; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        buf_r[0]   <= a3_1;
                        buf_r[1]   <= a3_2;
                        buf_r[2]   <= a3_3;
                        buf_r[3]   <= a3_4;
                        buf_r[4]   <= a3_5;
                        buf_r[5]   <= a3_6;
                        buf_r[6]   <= a3_7;
                        buf_r[7]   <= a3_8;
                        buf_r[8]   <= a3_9;
                        best_r     <= a3_1;
                        idx_r      <= 4'd1;
                        second_r   <= {1'b1, {(DATA_W-1){1'b0}}};
                        cnt_r      <= 4'd2;
                        in_ready_r <= 1'b0;
                        state_r    <= SCAN;
                    end
                end
                SCAN: begin
                    best_r   <= best_n_s;
                    second_r <= second_n_s;
                    idx_r    <= idx_n_s;
                    if (cnt_r == 4'd9) begin
                        class_idx_r <= idx_n_s;
                        max_val_r   <= best_n_s;
                        margin_r    <= margin_s;
                        low_conf_r  <= low_conf_s;
                        out_valid_r <= 1'b1;
                        cnt_r       <= 4'd0;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    cnt_r       <= 4'd0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign class_idx = class_idx_r;
    assign max_val   = max_val_r;
    assign margin    = margin_r;
    assign low_conf  = low_conf_r;

endmodule

// File: tb/tb_neuron_out_argmax.sv
// Bench for neuron_out_argmax: directed vectors with literal results, then random
// traffic checked every cycle against a transaction-level argmax model.
module tb_neuron_out_argmax;

    typedef struct packed {
        logic [3:0]  cls;
        logic [19:0] mx;
        logic [19:0] mg;
        logic        lc;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] a3_v [1:9];
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  class_idx;
    logic [19:0] max_val;
    logic [19:0] margin;
    logic        low_conf;

    int n_pass  = 0;
    int n_total = 0;

    // model state: phase 0 idle, 1..8 busy, 9 holding result
    int   m_phase;
    logic m_ready;
    logic m_valid;
    res_t m_res;
    res_t m_out;

    neuron_out_argmax dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a3_1(a3_v[1]), .a3_2(a3_v[2]), .a3_3(a3_v[3]),
        .a3_4(a3_v[4]), .a3_5(a3_v[5]), .a3_6(a3_v[6]),
        .a3_7(a3_v[7]), .a3_8(a3_v[8]), .a3_9(a3_v[9]),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .max_val(max_val),
        .margin(margin), .low_conf(low_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Argmax straight from the rules: first maximum wins, margin to max of the rest.
    function automatic res_t ref_model(input logic [179:0] vec);
        int   v [9];
        int   best;
        int   second;
        int   idx;
        res_t r;
        for (int k = 0; k < 9; k++) v[k] = int'($signed(vec[k*20 +: 20]));
        best = v[0];
        idx  = 0;
        for (int k = 1; k < 9; k++) if (v[k] > best) begin best = v[k]; idx = k; end
        second = -(1 << 19);
        for (int k = 0; k < 9; k++) if (k != idx && v[k] > second) second = v[k];
        r.cls = 4'(idx + 1);
        r.mx  = 20'(best);
        r.mg  = 20'(best - second);
        r.lc  = ((best - second) < 1024);
        return r;
    endfunction

    function automatic logic [179:0] cur_vec();
        return {a3_v[9], a3_v[8], a3_v[7], a3_v[6], a3_v[5], a3_v[4], a3_v[3], a3_v[2], a3_v[1]};
    endfunction

    // Transaction-timing model: accept, eight scan cycles, hold until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_out   <= '0;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_res   <= ref_model(cur_vec());
                m_ready <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase < 8) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == 8) begin
            m_out   <= m_res;
            m_valid <= 1'b1;
            m_phase <= 9;
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
            m_phase <= 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            chk("class_idx", class_idx, m_out.cls);
            chk("max_val", max_val, m_out.mx);
            chk("margin", margin, m_out.mg);
            chk("low_conf", low_conf, m_out.lc);
        end
    end

    function automatic logic [19:0] rand_val();
        logic [19:0] set_v [5];
        set_v[0] = 20'h80000; set_v[1] = 20'h7FFFF; set_v[2] = 20'h00000;
        set_v[3] = 20'h00400; set_v[4] = 20'hFFFFF;
        case ($urandom_range(0, 3))
            0:       return 20'($urandom);
            1:       return set_v[$urandom_range(0, 4)];
            2:       return 20'($urandom_range(0, 2047));
            default: return 20'hFFC00 + 20'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic set_vec(input logic [179:0] vec);
        for (int k = 1; k <= 9; k++) a3_v[k] = vec[(k-1)*20 +: 20];
    endtask

    task automatic send(input logic [179:0] vec);
        @(negedge clk);
        set_vec(vec);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) a3_v[k] = rand_val();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 8);
    endtask

    task automatic expect_res(input string name, input logic [3:0] c, input logic [19:0] mx,
                              input logic [19:0] mg, input logic lc);
        chk({name, "_class"}, class_idx, c);
        chk({name, "_max"}, max_val, mx);
        chk({name, "_margin"}, margin, mg);
        chk({name, "_lowconf"}, low_conf, lc);
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drop_valid"}, out_valid, 1'b0);
        chk({name, "_ready_back"}, in_ready, 1'b1);
    endtask

    function automatic logic [179:0] build(input logic [19:0] dflt, input int k1, input logic [19:0] v1,
                                           input int k2, input logic [19:0] v2);
        logic [179:0] vec;
        for (int k = 1; k <= 9; k++) begin
            vec[(k-1)*20 +: 20] = (k == k1) ? v1 : ((k == k2) ? v2 : dflt);
        end
        return vec;
    endfunction

    initial begin
        logic [179:0] vec;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) a3_v[k] = 20'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);

        // distinct values, max at class 5
        for (int k = 1; k <= 9; k++) vec[(k-1)*20 +: 20] = 20'(k * 256);
        vec[4*20 +: 20] = 20'h05AF4;
        send(vec);
        wait_valid("t2");
        expect_res("t2", 4'd5, 20'h05AF4, 20'h051F4, 1'b0);

        // asynchronous reset while holding a result, checked before any edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_valid", out_valid, 1'b0);
        chk("t1_ready", in_ready, 1'b1);
        expect_res("t1", 4'd0, 20'h0, 20'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        send(build(20'hFED26, 3, 20'h00200, 7, 20'h00200));
        wait_valid("t3");
        expect_res("t3", 4'd3, 20'h00200, 20'h0, 1'b1);
        consume("t3");

        send(build(20'h80000, 0, 20'h0, 0, 20'h0));
        wait_valid("t4");
        expect_res("t4", 4'd1, 20'h80000, 20'h0, 1'b1);
        consume("t4");

        // backpressure: descending vector, then noise on inputs while held
        for (int k = 1; k <= 9; k++) vec[(k-1)*20 +: 20] = 20'((10 - k) * 4096);
        send(vec);
        wait_valid("t5");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            for (int k = 1; k <= 9; k++) a3_v[k] = rand_val();
            chk("t5_ready_low", in_ready, 1'b0);
            chk("t5_valid_held", out_valid, 1'b1);
            expect_res("t5_hold", 4'd1, 20'h09000, 20'h01000, 1'b0);
        end
        in_valid = 1'b0;
        consume("t5");

        // margin exactly at threshold, then one below
        send(build(20'h00400, 8, 20'h00800, 0, 20'h0));
        wait_valid("t5b");
        expect_res("t5b", 4'd8, 20'h00800, 20'h00400, 1'b0);
        consume("t5b");
        send(build(20'h0, 4, 20'h003FF, 0, 20'h0));
        wait_valid("t5c");
        expect_res("t5c", 4'd4, 20'h003FF, 20'h003FF, 1'b1);
        consume("t5c");

        // reset in the middle of a scan
        send(build(20'h00100, 2, 20'h00500, 0, 20'h0));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_no_valid", out_valid, 1'b0);
        end
        send(build(20'h0, 9, 20'h7FFFF, 0, 20'h0));
        wait_valid("t6");
        expect_res("t6", 4'd9, 20'h7FFFF, 20'h7FFFF, 1'b0);
        consume("t6");

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 1; k <= 9; k++) a3_v[k] = rand_val();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/neuron_out_argmax.md
Name: neuron_out_argmax

Overview:
Consumer for the nine signed output-layer activations a3_1..a3_9 produced by neuron_out. On a valid/ready handshake it captures all nine values into a local buffer. It then scans them serially, one element per cycle, tracking the largest and second-largest value. It reports the winning class index, the winning value, and the top-two margin on an output valid/ready handshake. This is the decision stage that sits after the output layer of the network.

Parameters:
DATA_W, 20, width of each signed fixed-point activation; must match neuron_out.
MIN_MARGIN, 20'd1024, unsigned threshold in LSBs; a margin below it flags a low-confidence decision.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  a3_1..a3_9 are valid this cycle.
in_ready  output  1  block can accept a new vector.
a3_1 .. a3_9  input  DATA_W each (signed)  output-layer activations, classes 1..9.
out_valid  output  1  result fields are valid.
out_ready  input  1  downstream accepts the result.
class_idx  output  4  winning class, 1..9.
max_val  output  DATA_W (signed)  winning activation.
margin  output  DATA_W (unsigned)  max_val minus second-largest value.
low_conf  output  1  margin < MIN_MARGIN.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset forces all of the following immediately, regardless of state:
  - state=IDLE, in_ready=1, out_valid=0.
  - class_idx=0, max_val=0, margin=0, low_conf=0.
  - scan counter=0, buffer cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch all nine inputs into the buffer.
  - At that same edge, load best=a3_1, idx=1, second=-2^(DATA_W-1), cnt=2, then go to SCAN.
- SCAN:
  - in_ready=0; in_valid is ignored.
  - Each edge compares buffer element x=buf[cnt] (signed compare):
    - if x > best: second=best, best=x, idx=cnt.
    - else if x > second: second=x.
    - then cnt=cnt+1.
  - Ties go to the lower index: equal-to-best does not replace best, but it does update second, so margin=0.
  - Edge processing cnt=9: go to DONE and register the outputs:
    - class_idx=idx, max_val=best.
    - margin=best-second, computed at DATA_W+1 bits; the result is always ≥0 and fits DATA_W unsigned.
    - low_conf=(margin<MIN_MARGIN).
    - out_valid=1.
- Latency: out_valid is high 8 cycles after the accepting edge (edges E1..E8 scan elements 2..9).
- DONE:
  - out_valid=1 and all result fields are held stable until an edge with out_ready=1.
  - On that edge: out_valid=0, go to IDLE. in_ready returns to 1 on the following cycle; there is no same-cycle bypass.
- Throughput: at most one vector per 10 cycles when out_ready is held high.
- The output fields keep their last values after out_valid drops and are only updated at the end of the next scan.
- The input buffer is immune to changes on a3_* after capture.
- Reset asserted mid-SCAN or in DONE: the current result is discarded and no out_valid pulse is produced.

Test Plan:
1. Reset: assert rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1, class_idx=0, max_val=0, margin=0, low_conf=0, with no clock edge required.
2. Distinct values: a3_k=k*0x00100 for k≠5, a3_5=0x05AF4; pulse in_valid -> 8 cycles later out_valid=1, class_idx=5, max_val=0x05AF4, margin=0x05AF4-0x00900=0x051F4, low_conf=0.
3. Tie with negatives: all inputs 0xFED26 except a3_3=a3_7=0x00200 -> class_idx=3, max_val=0x00200, margin=0, low_conf=1.
4. All most-negative: all a3_k=0x80000 -> class_idx=1, max_val=0x80000, margin=0, low_conf=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and changing a3_* -> outputs stable, in_ready=0, no new capture. Raise out_ready -> out_valid drops next edge, in_ready=1 one cycle later. The next vector yields its own correct result.
6. Reset mid-SCAN: deassert rst_n at the 4th scan cycle, release, then send a vector with max at a3_9=0x7FFFF and all others 0 -> no spurious out_valid; result class_idx=9, max_val=0x7FFFF, margin=0x7FFFF.
